// File: rtl/alu_exec_array_pkg.sv
// rv32i_types: shared types for the execution back end.
// Station entry, result bus, ALU/compare encodings and lane state.
package rv32i_types;

  localparam int EX_UNITS = 4;
  localparam int ROB_W    = 4;

  typedef enum logic [3:0] {
    alu_add = 4'd0,
    alu_sll = 4'd1,
    alu_sra = 4'd2,
    alu_sub = 4'd3,
    alu_xor = 4'd4,
    alu_srl = 4'd5,
    alu_or  = 4'd6,
    alu_and = 4'd7
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } lane_state_t;

  typedef struct packed {
    logic             valid;
    logic             r1;
    logic             r2;
    logic [31:0]      rs1_v;
    logic [31:0]      rs2_v;
    alu_ops           aluop;
    branch_funct3_t   cmpop;
    logic             alu_cmp;
    logic [ROB_W-1:0] rob_id_dest;
  } rs_d;

  typedef struct packed {
    logic             ready;
    logic [ROB_W-1:0] rob_id;
    logic [31:0]      rd_data;
  } ex_data_bus_t;

  // Unknown aluop / cmpop encodings quietly produce zero.
  function automatic logic [31:0] exec_fn(
    input logic [31:0]    a,
    input logic [31:0]    b,
    input alu_ops         op,
    input branch_funct3_t f,
    input logic           is_cmp
  );
    logic [31:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    case (op)
      alu_add: r = a + b;
      alu_sll: r = a << b[4:0];
      alu_sra: r = $unsigned($signed(a) >>> b[4:0]);
      alu_sub: r = a - b;
      alu_xor: r = a ^ b;
      alu_srl: r = a >> b[4:0];
      alu_or:  r = a | b;
      alu_and: r = a & b;
      default: r = '0;
    endcase
    case (f)
      beq:     c = (a == b);
      bne:     c = (a != b);
      blt:     c = ($signed(a) < $signed(b));
      bge:     c = ($signed(a) >= $signed(b));
      bltu:    c = (a < b);
      bgeu:    c = (a >= b);
      default: c = 1'b0;
    endcase
    return is_cmp ? {31'b0, c} : r;
  endfunction

endpackage

// File: rtl/alu_exec_array_if.sv
// alu_exec_array_if: station-to-execute bundle.
// master drives rs_data/branch_mispredict; slave returns ex_data_bus/lane_busy.
interface alu_exec_array_if
  import rv32i_types::*;
#(
  parameter int SIZE = EX_UNITS
);
  logic                          branch_mispredict;
  rs_d          [SIZE-1:0]       rs_data;
  ex_data_bus_t [SIZE-1:0]       ex_data_bus;
  logic         [SIZE-1:0]       lane_busy;

  modport master (
    output branch_mispredict,
    output rs_data,
    input  ex_data_bus,
    input  lane_busy
  );

  modport slave (
    input  branch_mispredict,
    input  rs_data,
    output ex_data_bus,
    output lane_busy
  );
endinterface

// File: rtl/alu_exec_array_lane.sv
// alu_exec_lane: one execute lane, IDLE -> EXEC -> DONE -> IDLE.
// Ports: clk, rst, flush_i, ent_i (station entry), bus_o (result), busy_o.
// ALU_EXEC_FAST_EN: skip EXEC, compute in IDLE (2-cycle latency).
module alu_exec_lane
  import rv32i_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  rs_d          ent_i,
  output ex_data_bus_t bus_o,
  output logic         busy_o
);
  lane_state_t      state_q, state_d;
  logic [31:0]      res_q, res_d;
  logic [ROB_W-1:0] rob_q, rob_d;
  logic             go;

  assign go = ent_i.valid & ent_i.r1 & ent_i.r2;

`ifndef ALU_EXEC_FAST_EN
  logic [31:0]    a_q, a_d, b_q, b_d;
  alu_ops         op_q, op_d;
  branch_funct3_t f_q, f_d;
  logic           c_q, c_d;
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rob_d   = rob_q;
`ifndef ALU_EXEC_FAST_EN
    a_d  = a_q;
    b_d  = b_q;
    op_d = op_q;
    f_d  = f_q;
    c_d  = c_q;
`endif
    if (flush_i) begin
      state_d = IDLE;
      res_d   = '0;
      rob_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            rob_d = ent_i.rob_id_dest;
`ifdef ALU_EXEC_FAST_EN
            res_d = exec_fn(ent_i.rs1_v, ent_i.rs2_v,
                            ent_i.aluop, ent_i.cmpop,
                            ent_i.alu_cmp);
            state_d = DONE;
`else
            a_d     = ent_i.rs1_v;
            b_d     = ent_i.rs2_v;
            op_d    = ent_i.aluop;
            f_d     = ent_i.cmpop;
            c_d     = ent_i.alu_cmp;
            state_d = EXEC;
`endif
          end
        end
`ifndef ALU_EXEC_FAST_EN
        EXEC: begin
          res_d   = exec_fn(a_q, b_q, op_q, f_q, c_q);
          state_d = DONE;
        end
`endif
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      rob_q   <= '0;
`ifndef ALU_EXEC_FAST_EN
      a_q  <= '0;
      b_q  <= '0;
      op_q <= alu_add;
      f_q  <= beq;
      c_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rob_q   <= rob_d;
`ifndef ALU_EXEC_FAST_EN
      a_q  <= a_d;
      b_q  <= b_d;
      op_q <= op_d;
      f_q  <= f_d;
      c_q  <= c_d;
`endif
    end
  end

  // Bus stays all-zero outside the one DONE cycle.
  always_comb begin
    bus_o.ready   = (state_q == DONE);
    bus_o.rob_id  = bus_o.ready ? rob_q : '0;
    bus_o.rd_data = bus_o.ready ? res_q : '0;
  end

  assign busy_o = (state_q != IDLE);
endmodule

// File: rtl/alu_exec_array.sv
// alu_exec_array: SIZE independent execute lanes behind the stations.
// Ports: clk, rst (sync, active-high), bus (alu_exec_array_if.slave).
// ALU_EXEC_FAST_EN selects the 2-cycle lane variant.
module alu_exec_array
  import rv32i_types::*;
#(
  parameter int SIZE = EX_UNITS
)(
  input logic             clk,
  input logic             rst,
  alu_exec_array_if.slave bus
);
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    alu_exec_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .flush_i (bus.branch_mispredict),
      .ent_i   (bus.rs_data[i]),
      .bus_o   (bus.ex_data_bus[i]),
      .busy_o  (bus.lane_busy[i])
    );
  end
endmodule
